// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone classic signals of wb_cmd_master.
// master = the initiator's view; slave = host plus bus side.
interface wb_cmd_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_write;
  logic       rsp_err;
  logic [7:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_cyc_o;
  logic       wb_stb_o;
  logic       wb_we_o;
  logic       wb_ack_i;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data,
    input  rsp_ready, wb_dat_i, wb_ack_i,
    output cmd_ready, rsp_valid, rsp_data,
    output rsp_write, rsp_err,
    output wb_adr_o, wb_dat_o, wb_cyc_o,
    output wb_stb_o, wb_we_o
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_data,
    output rsp_ready, wb_dat_i, wb_ack_i,
    input  cmd_ready, rsp_valid, rsp_data,
    input  rsp_write, rsp_err,
    input  wb_adr_o, wb_dat_o, wb_cyc_o,
    input  wb_stb_o, wb_we_o
  );
endinterface

// File: rtl/wb_cmd_master.sv
// Command stream to single 8-bit Wishbone classic cycles,
// one response per command, with a bus timeout.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_cmd_master_if.master bus,
  output logic       busy,
  output logic [7:0] err_count
);

  localparam int unsigned CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic          we_q, we_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rerr_q, rerr_d;
  logic          rwr_q, rwr_d;
  logic [7:0]    errc_q, errc_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    rwr_d   = rwr_q;
    errc_d  = errc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          adr_d   = bus.cmd_addr;
          dat_d   = bus.cmd_data;
          we_d    = bus.cmd_write;
          rwr_d   = bus.cmd_write;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // ack has priority over an expiring timeout
        if (bus.wb_ack_i) begin
          we_d    = 1'b0;
          rdata_d = we_q ? 8'h00 : bus.wb_dat_i;
          rerr_d  = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          we_d    = 1'b0;
          rdata_d = 8'h00;
          rerr_d  = 1'b1;
          if (errc_q != 8'hFF) begin
            errc_d = errc_q + 8'd1;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= 8'h00;
      dat_q   <= 8'h00;
      we_q    <= 1'b0;
      rdata_q <= 8'h00;
      rerr_q  <= 1'b0;
      rwr_q   <= 1'b0;
      errc_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      rwr_q   <= rwr_d;
      errc_q  <= errc_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_err   = rerr_q;
  assign bus.rsp_write = rwr_q;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_cyc_o  = (state_q == BUS);
  assign bus.wb_stb_o  = (state_q == BUS);
  assign busy          = (state_q != IDLE);
  assign err_count     = errc_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomised bench for wb_cmd_master against a 1-cycle-ack
// slave and a memory/error-count reference model.
module tb_wb_cmd_master;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [7:0] err_count;

  wb_cmd_master_if bus();

  wb_cmd_master #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .busy     (busy),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] init_val(int i);
    if (i == 'h10) return 8'h03;
    if (i == 'h11) return 8'h02;
    return 8'(i) ^ 8'h5A;
  endfunction

  // slave: acks one cycle after seeing stb
  logic [7:0] slv_mem [256];
  bit         mem_ok;
  logic       slv_en;
  logic       ack_q;
  logic       force_ack;

  assign bus.wb_ack_i = ack_q | force_ack;
  assign bus.wb_dat_i = slv_mem[bus.wb_adr_o];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      if (!mem_ok) begin
        for (int i = 0; i < 256; i++) slv_mem[i] <= init_val(i);
        mem_ok <= 1'b1;
      end
    end else if (slv_en && bus.wb_cyc_o && bus.wb_stb_o && !ack_q) begin
      ack_q <= 1'b1;
      if (bus.wb_we_o) slv_mem[bus.wb_adr_o] <= bus.wb_dat_o;
    end else begin
      ack_q <= 1'b0;
    end
  end

  // bus rule monitor
  int stb_bad = 0;
  int run = 0;
  int max_run = 0;
  always @(negedge clk) begin
    if (bus.wb_stb_o !== bus.wb_cyc_o) stb_bad <= stb_bad + 1;
    run <= bus.wb_cyc_o ? run + 1 : 0;
    if (bus.wb_cyc_o && run + 1 > max_run) max_run <= run + 1;
  end

  // reference model
  logic [7:0] ref_mem [256];
  int         exp_err = 0;

  logic [7:0] r_d;
  logic       r_e, r_w;
  int         lat, cyc_n, we_n, hold_n;

  task automatic send(input logic w, input logic [7:0] a,
                      input logic [7:0] d);
    int g;
    g = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    while (bus.cmd_ready !== 1'b1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: got %b want 1", bus.cmd_ready);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic collect(input logic [7:0] ea, input logic [7:0] ed,
                         output logic [7:0] d, output logic e,
                         output logic wr, output int l,
                         output int cn, output int wn, output int hn);
    l = 0; cn = 0; wn = 0; hn = 0;
    while (bus.rsp_valid !== 1'b1 && l < 100) begin
      if (bus.wb_cyc_o === 1'b1) begin
        cn++;
        if (bus.wb_we_o === 1'b1) wn++;
        if (bus.wb_adr_o === ea && bus.wb_dat_o === ed) hn++;
      end
      @(posedge clk);
      #1 l++;
    end
    d  = bus.rsp_data;
    e  = bus.rsp_err;
    wr = bus.rsp_write;
  endtask

  task automatic release_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready);
    end
    n_tests++;
    if ({bus.rsp_valid, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, busy}
        !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_ctrl: got %b want 00000",
               {bus.rsp_valid, bus.wb_cyc_o, bus.wb_stb_o,
                bus.wb_we_o, busy});
    end
    n_tests++;
    if ({err_count, bus.rsp_data, bus.wb_adr_o, bus.wb_dat_o} !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_data: got %h want 0",
               {err_count, bus.rsp_data, bus.wb_adr_o, bus.wb_dat_o});
    end
    n_tests++;
    if ({bus.rsp_err, bus.rsp_write} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_rsp_flags: got %b want 00",
               {bus.rsp_err, bus.rsp_write});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_write();
    send(1'b1, 8'h10, 8'h01);
    collect(8'h10, 8'h01, r_d, r_e, r_w, lat, cyc_n, we_n, hold_n);
    ref_mem[8'h10] = 8'h01;
    n_tests++;
    if (we_n != 2 || hold_n != 2) begin
      n_fail++;
      $display("FAIL wr_bus: we %0d hold %0d want 2 2", we_n, hold_n);
    end
    n_tests++;
    if ({r_w, r_d, r_e} !== {1'b1, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_rsp: got w%b d%h e%b want w1 d00 e0",
               r_w, r_d, r_e);
    end
    n_tests++;
    if (lat != 2) begin
      n_fail++; $display("FAIL wr_lat: got %0d want 2", lat);
    end
    release_rsp();
    n_tests++;
    if (slv_mem[8'h10] !== 8'h01) begin
      n_fail++; $display("FAIL wr_mem: got %h want 01", slv_mem[8'h10]);
    end
  endtask

  task automatic test_read();
    send(1'b0, 8'h11, 8'hAA);
    collect(8'h11, 8'hAA, r_d, r_e, r_w, lat, cyc_n, we_n, hold_n);
    n_tests++;
    if ({r_w, r_d, r_e} !== {1'b0, ref_mem[8'h11], 1'b0}) begin
      n_fail++;
      $display("FAIL rd_rsp: got w%b d%h e%b want w0 d%h e0",
               r_w, r_d, r_e, ref_mem[8'h11]);
    end
    n_tests++;
    if (lat != 2 || cyc_n != 2 || we_n != 0) begin
      n_fail++;
      $display("FAIL rd_timing: lat %0d cyc %0d we %0d want 2 2 0",
               lat, cyc_n, we_n);
    end
    release_rsp();
  endtask

  task automatic test_timeout();
    slv_en = 1'b0;
    send(1'b0, 8'h40, 8'h00);
    collect(8'h40, 8'h00, r_d, r_e, r_w, lat, cyc_n, we_n, hold_n);
    if (exp_err < 255) exp_err++;
    n_tests++;
    if (cyc_n != TO || lat != TO) begin
      n_fail++;
      $display("FAIL to_len: cyc %0d lat %0d want %0d", cyc_n, lat, TO);
    end
    n_tests++;
    if ({r_e, r_d} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL to_rsp: got e%b d%h want e1 d00", r_e, r_d);
    end
    n_tests++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL to_cnt: got %0d want %0d", err_count, exp_err);
    end
    release_rsp();
    repeat (2) @(posedge clk);
    #1 force_ack = 1'b1;
    @(posedge clk);
    #1 force_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, bus.rsp_valid, bus.wb_cyc_o} !== 3'b000 ||
        err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL stray_ack: got b%b v%b c%b e%0d want 000 %0d",
               busy, bus.rsp_valid, bus.wb_cyc_o, err_count, exp_err);
    end
    slv_en = 1'b1;
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    send(1'b0, 8'h11, 8'h00);
    collect(8'h11, 8'h00, r_d, r_e, r_w, lat, cyc_n, we_n, hold_n);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h20;
    bus.cmd_data  = 8'h77;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ref_mem[8'h11] ||
          bus.cmd_ready !== 1'b0 || bus.wb_cyc_o !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold: %0d bad cycles, want 0", bad);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    n_tests++;
    if ({bus.cmd_ready, bus.wb_cyc_o, bus.rsp_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL bp_idle: got %b want 100",
               {bus.cmd_ready, bus.wb_cyc_o, bus.rsp_valid});
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    collect(8'h20, 8'h77, r_d, r_e, r_w, lat, cyc_n, we_n, hold_n);
    ref_mem[8'h20] = 8'h77;
    n_tests++;
    if ({r_w, r_e, r_d} !== {1'b1, 1'b0, 8'h00} || hold_n != 2) begin
      n_fail++;
      $display("FAIL bp_next: got w%b e%b d%h hold %0d", r_w, r_e, r_d,
               hold_n);
    end
    release_rsp();
  endtask

  task automatic test_ack_at_limit();
    slv_en = 1'b0;
    send(1'b0, 8'h11, 8'h00);
    repeat (TO - 1) @(posedge clk);
    #1 force_ack = 1'b1;
    @(posedge clk);
    #1 force_ack = 1'b0;
    n_tests++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !==
        {1'b1, 1'b0, ref_mem[8'h11]}) begin
      n_fail++;
      $display("FAIL ack_limit: got v%b e%b d%h want v1 e0 d%h",
               bus.rsp_valid, bus.rsp_err, bus.rsp_data, ref_mem[8'h11]);
    end
    n_tests++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL ack_limit_cnt: got %0d want %0d", err_count, exp_err);
    end
    release_rsp();
    slv_en = 1'b1;
  endtask

  task automatic test_reset_mid_bus();
    slv_en = 1'b0;
    send(1'b1, 8'h33, 8'h44);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid: got %b want 0000",
               {bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_err = 0;
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || err_count !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_after: rdy %b cnt %0d want 1 0",
               bus.cmd_ready, err_count);
    end
    slv_en = 1'b1;
  endtask

  task automatic test_saturate();
    int bad;
    bad = 0;
    slv_en = 1'b0;
    for (int i = 0; i < 260; i++) begin
      send(1'b0, 8'($urandom), 8'h00);
      collect(bus.cmd_addr, bus.cmd_data, r_d, r_e, r_w,
              lat, cyc_n, we_n, hold_n);
      if (exp_err < 255) exp_err++;
      if (r_e !== 1'b1 || r_d !== 8'h00 || err_count !== 8'(exp_err))
        bad++;
      release_rsp();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL sat_steps: %0d bad, want 0", bad);
    end
    n_tests++;
    if (err_count !== 8'hFF) begin
      n_fail++; $display("FAIL sat_final: got %h want ff", err_count);
    end
    slv_en = 1'b1;
  endtask

  task automatic test_random();
    logic       w;
    logic [7:0] a, d, xd;
    logic       xe;
    int         xl, hold, bad;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      slv_en = ($urandom_range(0, 3) != 0);
      w = 1'($urandom);
      a = 8'($urandom);
      d = 8'($urandom);
      send(w, a, d);
      collect(a, d, r_d, r_e, r_w, lat, cyc_n, we_n, hold_n);
      if (slv_en) begin
        xd = w ? 8'h00 : ref_mem[a];
        xe = 1'b0;
        xl = 2;
        if (w) ref_mem[a] = d;
      end else begin
        xd = 8'h00;
        xe = 1'b1;
        xl = TO;
        if (exp_err < 255) exp_err++;
      end
      n_tests++;
      if ({r_d, r_e, r_w} !== {xd, xe, w} || lat != xl || hold_n != xl) begin
        n_fail++;
        $display("FAIL rnd_%0d: got d%h e%b w%b l%0d want d%h e%b w%b l%0d",
                 i, r_d, r_e, r_w, lat, xd, xe, w, xl);
      end
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        @(posedge clk);
        #1;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== xd ||
            bus.rsp_err !== xe || bus.rsp_write !== w) bad++;
      end
      release_rsp();
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rnd_stable: %0d bad cycles", bad);
    end
    n_tests++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL rnd_errcnt: got %0d want %0d", err_count, exp_err);
    end
    bad = 0;
    for (int j = 0; j < 256; j++) if (slv_mem[j] !== ref_mem[j]) bad++;
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rnd_mem: %0d words differ", bad);
    end
    slv_en = 1'b1;
  endtask

  task automatic test_bus_rules();
    n_tests++;
    if (stb_bad != 0) begin
      n_fail++; $display("FAIL stb_cyc: %0d cycles differ", stb_bad);
    end
    n_tests++;
    if (max_run != TO) begin
      n_fail++; $display("FAIL cyc_run: got %0d want %0d", max_run, TO);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h00;
    bus.cmd_data  = 8'h00;
    bus.rsp_ready = 1'b0;
    force_ack     = 1'b0;
    slv_en        = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_ack_at_limit();
    test_reset_mid_bus();
    test_saturate();
    test_random();
    test_bus_rules();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
